// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a program image as a byte stream
// (32-bit little-endian word count N, then N little-endian words) and
// writes it one word per cycle into the instruction store write port.
// While a load is running the core is held in reset through busy_o.
module imem_loader #(
    parameter int              WIDTH      = 32,
    parameter int              DEPTH_LOG2 = 10,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             we_o,
    output logic [WIDTH-1:0] waddr_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    // Largest legal word count; headers above this are rejected whole.
    localparam logic [31:0] MAX_N = 32'd1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q,    state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           count_q,    count_d;
    logic [31:0]           word_q,     word_d;
    logic [DEPTH_LOG2:0]   idx_q,      idx_d;
    logic [WIDTH-1:0]      waddr_q,    waddr_d;
    logic [WIDTH-1:0]      wdata_q,    wdata_d;
    logic                  done_q,     done_d;
    logic                  err_q,      err_d;

    logic                  xfer;
    logic [31:0]           count_ins;
    logic [31:0]           word_ins;
    logic [DEPTH_LOG2:0]   idx_inc;

    // Handshake depends on state alone, so there is no path from byte_valid_i.
    assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA);
    assign busy_o       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
    assign we_o         = (state_q == S_WRITE);
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

    assign xfer    = byte_valid_i & byte_ready_o;
    assign idx_inc = idx_q + 1'b1;

    // Value of the count/word registers with the incoming byte dropped into
    // the lane selected by the byte counter (little-endian assembly).
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign count_ins[8*gi +: 8] = (byte_cnt_q == 2'(gi)) ? byte_data_i : count_q[8*gi +: 8];
        assign word_ins[8*gi +: 8]  = (byte_cnt_q == 2'(gi)) ? byte_data_i : word_q[8*gi +: 8];
    end

    // State register and all datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            count_q    <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: header capture, word assembly, write sequencing.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        count_d    = count_q;
        word_d     = word_q;
        idx_d      = idx_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d    = S_LEN;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    byte_cnt_d = '0;
                    count_d    = '0;
                    word_d     = '0;
                    idx_d      = '0;
                end
            end

            S_LEN: begin
                if (xfer) begin
                    count_d    = count_ins;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (count_ins == 32'd0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else if (count_ins > MAX_N) begin
                            // Oversized image: refuse it before any write happens.
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    word_d     = word_ins;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        waddr_d = BASE_ADDR + WIDTH'({idx_q, 2'b00});
                        wdata_d = WIDTH'(word_ins);
                    end
                end
            end

            S_WRITE: begin
                idx_d = idx_inc;
                if (32'(idx_inc) == count_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed image loads driven byte by byte, an
// expected-write queue plus a small status model, and one monitor that
// compares the DUT against them on every falling clock edge.
module tb_imem_loader;

    localparam int DL2  = 10;
    localparam int MAXN = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, we, busy, done, err;
    logic [31:0] waddr, wdata;

    always #5 clk = ~clk;

    imem_loader #(.WIDTH(32), .DEPTH_LOG2(DL2), .BASE_ADDR(32'h0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .byte_valid_i(byte_valid),
        .byte_data_i (byte_data),
        .byte_ready_o(byte_ready),
        .we_o        (we),
        .waddr_o     (waddr),
        .wdata_o     (wdata),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of the loader as seen from outside.
    bit          m_busy = 0, m_done = 0, m_err = 0;
    bit          exp_we = 0, fin_pend = 0, mon_en = 0;
    int          words_left = 0;
    int          n_writes = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] img [0:MAXN-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fin_pend) begin
                m_busy   = 0;
                m_done   = 1;
                fin_pend = 0;
            end
            check("we", {31'b0, we}, {31'b0, exp_we});
            check("byte_ready", {31'b0, byte_ready}, {31'b0, m_busy && !exp_we});
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("done", {31'b0, done}, {31'b0, m_done});
            check("err",  {31'b0, err},  {31'b0, m_err});
            if (we === 1'b1) begin
                n_writes++;
                if (q_addr.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write", waddr, wdata);
                end else begin
                    $display("write addr=0x%08h data=0x%08h", waddr, wdata);
                    check("waddr", waddr, q_addr.pop_front());
                    check("wdata", wdata, q_data.pop_front());
                    words_left--;
                    if (words_left == 0) fin_pend = 1;
                end
            end
            exp_we = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL byte_accept: got no byte_ready in 50 cycles, expected acceptance");
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!m_busy) begin
            m_busy = 1;
            m_done = 0;
            m_err  = 0;
        end
    endtask

    task automatic send_header(input logic [31:0] n, input int gapmax);
        bit ok;
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], $urandom_range(0, gapmax), ok);
        if (n == 0) begin
            m_busy = 0;
            m_done = 1;
        end else if (n > MAXN) begin
            m_busy = 0;
            m_done = 1;
            m_err  = 1;
        end else begin
            words_left = n;
        end
    endtask

    // Send bytes [first, last] of data word idx; completing a word queues its write.
    task automatic send_word_part(input int idx, input int first, input int last, input int gapmax);
        bit ok;
        logic [31:0] w;
        w = img[idx];
        for (int k = first; k <= last; k++) begin
            send_byte(w[8*k +: 8], $urandom_range(0, gapmax), ok);
            if (k == 3) begin
                q_addr.push_back(32'(idx) * 4);
                q_data.push_back(w);
                exp_we = 1;
            end
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got done=0 for 20 cycles, expected done=1");
        end
    endtask

    task automatic load(input logic [31:0] n, input int gapmax);
        start_pulse();
        send_header(n, gapmax);
        if (n != 0 && n <= MAXN)
            for (int i = 0; i < int'(n); i++) send_word_part(i, 0, 3, gapmax);
        wait_done();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_busy = 0; m_done = 0; m_err = 0;
        exp_we = 0; fin_pend = 0; words_left = 0;
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish by 900000 ns, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbase;
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        tick();
        mon_en = 1;
        tick();
        do_reset();
        @(negedge clk);
        check("reset_waddr", waddr, 32'h0);
        check("reset_wdata", wdata, 32'h0);
        tick();

        // 1: single word
        img[0] = 32'h00A00513;
        wbase = n_writes;
        load(32'd1, 0);
        check("t1_waddr", waddr, 32'h0);
        check("t1_wdata", wdata, 32'h00A00513);
        check("t1_done", {31'b0, done}, 32'd1);
        check("t1_nwr", 32'(n_writes - wbase), 32'd1);
        // bytes offered while DONE must not be taken
        byte_valid = 1'b1; byte_data = 8'hAA;
        repeat (3) tick();
        byte_valid = 1'b0;

        // 2: three words back to back
        img[0] = 32'h11111111; img[1] = 32'h22222222; img[2] = 32'h33333333;
        wbase = n_writes;
        load(32'd3, 0);
        check("t2_waddr", waddr, 32'h8);
        check("t2_wdata", wdata, 32'h33333333);
        check("t2_nwr", 32'(n_writes - wbase), 32'd3);

        // 3: two words with random gaps
        img[0] = 32'hDEADBEEF; img[1] = 32'h0BADF00D;
        wbase = n_writes;
        load(32'd2, 5);
        check("t3_waddr", waddr, 32'h4);
        check("t3_wdata", wdata, 32'h0BADF00D);
        check("t3_nwr", 32'(n_writes - wbase), 32'd2);

        // 4: empty and oversized headers
        wbase = n_writes;
        load(32'd0, 0);
        check("t4_n0_err", {31'b0, err}, 32'd0);
        check("t4_hold_waddr", waddr, 32'h4);
        check("t4_hold_wdata", wdata, 32'h0BADF00D);
        load(32'h401, 0);
        check("t4_401_err", {31'b0, err}, 32'd1);
        load(32'h00010000, 0);
        check("t4_big_err", {31'b0, err}, 32'd1);
        check("t4_nwr", 32'(n_writes - wbase), 32'd0);

        // 5: reset in the middle of word 1, then a clean reload
        for (int i = 0; i < 4; i++) img[i] = 32'hA0000000 + 32'(i);
        start_pulse();
        send_header(32'd4, 0);
        send_word_part(0, 0, 3, 0);
        send_word_part(1, 0, 1, 0);
        do_reset();
        @(negedge clk);
        check("t5_rst_waddr", waddr, 32'h0);
        check("t5_rst_wdata", wdata, 32'h0);
        tick();
        wbase = n_writes;
        load(32'd4, 0);
        check("t5_waddr", waddr, 32'hC);
        check("t5_wdata", wdata, 32'hA0000003);
        check("t5_nwr", 32'(n_writes - wbase), 32'd4);

        // 6: start while loading is ignored; start after an error restarts
        img[0] = 32'h12345678; img[1] = 32'h9ABCDEF0;
        wbase = n_writes;
        start_pulse();
        send_header(32'd2, 0);
        send_word_part(0, 0, 3, 0);
        start_pulse();
        send_word_part(1, 0, 3, 0);
        wait_done();
        check("t6_waddr", waddr, 32'h4);
        check("t6_nwr", 32'(n_writes - wbase), 32'd2);
        load(32'h401, 0);
        img[0] = 32'hCAFEF00D;
        load(32'd1, 0);
        check("t6_restart_err", {31'b0, err}, 32'd0);
        check("t6_restart_wdata", wdata, 32'hCAFEF00D);

        // 7: full-depth image, last address at the top of the store
        for (int i = 0; i < MAXN; i++) img[i] = 32'(i) ^ 32'h5A5A0000;
        wbase = n_writes;
        load(32'(MAXN), 0);
        check("t7_waddr", waddr, 32'h00000FFC);
        check("t7_wdata", wdata, 32'h5A5A03FF);
        check("t7_nwr", 32'(n_writes - wbase), 32'd1024);
        check("t7_err", {31'b0, err}, 32'd0);

        repeat (2) tick();
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
